// File: rtl/hall_sim_ramp_ctrl.sv
// hall_sim_ramp_ctrl: rate-limited speed/direction scheduler that feeds
// the Hall simulator's enable, direction and step-period inputs.
// Ports: clk, reset (async, active-high); cmd_valid/cmd_ready handshake
// with cmd_enable, cmd_direction, cmd_duration, ramp_step, ramp_interval;
// outputs enable_sim, sim_direction, sim_speed_duration, busy, at_target.
module hall_sim_ramp_ctrl #(
  parameter int               DUR_W         = 32,
  parameter logic [DUR_W-1:0] SLOW_DURATION = 32'd1_000_000,
  parameter logic [DUR_W-1:0] MIN_DURATION  = 32'd2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_enable,
  input  logic             cmd_direction,
  input  logic [DUR_W-1:0] cmd_duration,
  input  logic [DUR_W-1:0] ramp_step,
  input  logic [15:0]      ramp_interval,
  output logic             enable_sim,
  output logic             sim_direction,
  output logic [DUR_W-1:0] sim_speed_duration,
  output logic             busy,
  output logic             at_target
);

  typedef enum logic [2:0] {
    S_IDLE, S_RAMP, S_HOLD, S_DECEL, S_REV
  } state_t;

  state_t           state_q, state_d;
  logic [DUR_W-1:0] goal_q, goal_d;
  logic [DUR_W-1:0] step_q, step_d;
  logic [15:0]      ival_q, ival_d;
  logic [15:0]      cnt_q, cnt_d;
  logic             ndir_q, ndir_d;
  logic             stop_q, stop_d;
  logic             en_q, en_d;
  logic             dir_q, dir_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic             rdy_q, rdy_d;
  logic             busy_q, busy_d;
  logic             at_q, at_d;

  logic             accept;
  logic             tick;
  logic             reach;
  logic [DUR_W-1:0] cmd_goal;
  logic [DUR_W-1:0] tgt;
  logic [DUR_W-1:0] nv;

  // One ramp step toward g; a zero step jumps straight to g.
  function automatic logic [DUR_W-1:0] nxt(
    input logic [DUR_W-1:0] c,
    input logic [DUR_W-1:0] g,
    input logic [DUR_W-1:0] s
  );
    if (c > g)
      nxt = (c - g <= s || s == '0) ? g : c - s;
    else
      nxt = (g - c <= s || s == '0) ? g : c + s;
  endfunction

  always_comb begin
    state_d = state_q;
    goal_d  = goal_q;
    step_d  = step_q;
    ival_d  = ival_q;
    ndir_d  = ndir_q;
    stop_d  = stop_q;
    en_d    = en_q;
    dir_d   = dir_q;
    dur_d   = dur_q;
    at_d    = 1'b0;
    accept  = cmd_valid && rdy_q;
    tick    = (cnt_q == ival_q - 16'd1);
    cnt_d   = tick ? 16'd0 : cnt_q + 16'd1;

    if (cmd_duration < MIN_DURATION)
      cmd_goal = MIN_DURATION;
    else if (cmd_duration > SLOW_DURATION)
      cmd_goal = SLOW_DURATION;
    else
      cmd_goal = cmd_duration;

    tgt   = (state_q == S_DECEL) ? SLOW_DURATION : goal_q;
    nv    = nxt(dur_q, tgt, step_q);
    reach = (dur_q == tgt) || (tick && nv == tgt);

    if (accept) begin
      goal_d = cmd_goal;
      step_d = ramp_step;
      ival_d = (ramp_interval == 16'd0) ? 16'd1 : ramp_interval;
      ndir_d = cmd_direction;
    end

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cmd_enable) begin
            state_d = S_RAMP;
            en_d    = 1'b1;
            dir_d   = cmd_direction;
            dur_d   = SLOW_DURATION;
          end else begin
            at_d = 1'b1;
          end
        end
      end
      S_RAMP: begin
        if (tick)
          dur_d = nv;
        if (reach) begin
          state_d = S_HOLD;
          dur_d   = tgt;
          at_d    = 1'b1;
        end
      end
      S_HOLD: begin
        if (accept) begin
          if (cmd_enable && cmd_direction == dir_q) begin
            state_d = S_RAMP;
          end else begin
            state_d = S_DECEL;
            stop_d  = !cmd_enable;
          end
        end
      end
      S_DECEL: begin
        if (tick)
          dur_d = nv;
        if (reach) begin
          dur_d = SLOW_DURATION;
          en_d  = 1'b0;
          if (stop_q) begin
            state_d = S_IDLE;
            at_d    = 1'b1;
          end else begin
            state_d = S_REV;
          end
        end
      end
      S_REV: begin
        state_d = S_RAMP;
        en_d    = 1'b1;
        dir_d   = ndir_q;
      end
      default: state_d = S_IDLE;
    endcase

    // Interval timing restarts on every accept and state entry.
    if (accept || state_d != state_q)
      cnt_d = 16'd0;

    rdy_d  = (state_d == S_IDLE) || (state_d == S_HOLD);
    busy_d = !rdy_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      goal_q  <= SLOW_DURATION;
      step_q  <= '0;
      ival_q  <= 16'd1;
      cnt_q   <= 16'd0;
      ndir_q  <= 1'b0;
      stop_q  <= 1'b0;
      en_q    <= 1'b0;
      dir_q   <= 1'b0;
      dur_q   <= SLOW_DURATION;
      rdy_q   <= 1'b1;
      busy_q  <= 1'b0;
      at_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      goal_q  <= goal_d;
      step_q  <= step_d;
      ival_q  <= ival_d;
      cnt_q   <= cnt_d;
      ndir_q  <= ndir_d;
      stop_q  <= stop_d;
      en_q    <= en_d;
      dir_q   <= dir_d;
      dur_q   <= dur_d;
      rdy_q   <= rdy_d;
      busy_q  <= busy_d;
      at_q    <= at_d;
    end
  end

  assign cmd_ready          = rdy_q;
  assign enable_sim         = en_q;
  assign sim_direction      = dir_q;
  assign sim_speed_duration = dur_q;
  assign busy               = busy_q;
  assign at_target          = at_q;

endmodule
